// File: rtl/ring_pattern_checker_pkg.sv
// Purpose: shared types, defaults and ring helpers for the ring pattern checker and chaser generator.
// Latency: n/a (types, constants and combinational functions only).
// Backpressure: n/a.
// Contents: ring_state_t FSM encoding, DEF_WIDTH/DEF_TIMEOUT defaults, rotl()/onehot() on a
//           zero-extended RING_MAX_W-bit vector so any WIDTH up to RING_MAX_W can reuse them.
package ring_pattern_checker_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } ring_state_t;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_TIMEOUT = 20_000_000;

    // Widest ring the helpers handle; callers zero-extend their bus into ring_vec_t.
    localparam int RING_MAX_W = 64;
    typedef logic [RING_MAX_W-1:0] ring_vec_t;

    // Rotate the low w bits of x left by one; the bit at w-1 wraps to bit 0.
    // Bits of x at or above w must be zero.
    function automatic ring_vec_t rotl(input ring_vec_t x, input int unsigned w);
        ring_vec_t mask;
        if (w >= RING_MAX_W)
            mask = '1;
        else
            mask = (ring_vec_t'(1) << w) - ring_vec_t'(1);
        return ((x << 1) | (x >> (w - 1))) & mask;
    endfunction

    // Exactly one bit set; all-zero and multi-hot both return 0.
    function automatic logic onehot(input ring_vec_t x);
        return (x != '0) && ((x & (x - ring_vec_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/ring_in_sync.sv
// Purpose: WIDTH-bit input register stage for the ring bus; 3 flops when RING_CHK_SYNC_EN is defined.
// Latency: 1 clk by default, 3 clk with RING_CHK_SYNC_EN (two metastability flops ahead of q).
// Backpressure: none; the bus is sampled every cycle.
// Ports: clk, rst_n (async active-low, all flops reset to 0), d (raw bus), q (registered bus).
module ring_in_sync
    import ring_pattern_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

`ifdef RING_CHK_SYNC_EN
    // d may be asynchronous to clk: meta1/meta2 give it two cycles to settle before use.
    logic [WIDTH-1:0] meta1;
    logic [WIDTH-1:0] meta2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta1 <= '0;
            meta2 <= '0;
            q     <= '0;
        end else begin
            meta1 <= d;
            meta2 <= meta1;
            q     <= meta2;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else
            q <= d;
    end
`endif

endmodule

// File: rtl/ring_pattern_checker.sv
// Purpose: locks onto a left-rotating one-hot ring bus, counts good steps, flags bad steps and stalls.
// Latency: ring_in edge to step/err pulse is 2 clk (4 clk with RING_CHK_SYNC_EN); all outputs registered.
// Backpressure: none; a pure monitor that samples ring_in every cycle.
// Ports: clk, rst_n (async active-low); ring_in[WIDTH]; locked, stall (sticky until the next bus
//        change), step_pulse, err_pulse, step_cnt[CNT_W] (wraps), err_cnt[CNT_W] (saturates).
// Option: define RING_CHK_SYNC_EN when ring_in is asynchronous to clk.
module ring_pattern_checker
    import ring_pattern_checker_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int TMR_W      = 25,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ring_in,
    output logic             locked,
    output logic             stall,
    output logic             step_pulse,
    output logic             err_pulse,
    output logic [CNT_W-1:0] step_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // run only needs to reach LOCK_COUNT-1: the step that would take it to LOCK_COUNT locks instead.
    localparam int                RUN_W    = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(LOCK_COUNT - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] prev_q;
    ring_state_t      state;
    logic [RUN_W-1:0] run;
    logic [TMR_W-1:0] tmr;

    ring_vec_t s_ext;
    ring_vec_t p_ext;
    logic      s_onehot;
    logic      p_onehot;
    logic      change;
    logic      good;
    logic      bad;

    ring_in_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ring_in),
        .q     (s_q)
    );

    assign s_ext    = ring_vec_t'(s_q);
    assign p_ext    = ring_vec_t'(prev_q);
    assign s_onehot = onehot(s_ext);
    assign p_onehot = onehot(p_ext);
    assign change   = (s_q != prev_q);
    // A good step needs a one-hot origin, so 0 -> one-hot or multi-hot -> anything is always bad.
    assign good     = change && p_onehot && (s_ext == rotl(p_ext, WIDTH));
    assign bad      = change && !good;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            prev_q     <= '0;
            run        <= '0;
            tmr        <= '0;
            locked     <= 1'b0;
            stall      <= 1'b0;
            step_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            step_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            prev_q     <= s_q;
            step_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            // Any movement on the bus releases a previous stall, whatever the state.
            if (change)
                stall <= 1'b0;

            case (state)
                HUNT: begin
                    if (s_onehot) begin
                        state <= LOCKING;
                        run   <= '0;
                    end
                end
                LOCKING: begin
                    if (good) begin
                        if (run == RUN_LAST) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            tmr    <= '0;
                        end else begin
                            run <= run + 1'b1;
                        end
                    end else if (bad) begin
                        state <= HUNT;
                    end
                end
                LOCKED: begin
                    // A change always takes priority over an expiring timer.
                    if (good) begin
                        step_pulse <= 1'b1;
                        step_cnt   <= step_cnt + 1'b1;
                        tmr        <= '0;
                    end else if (bad) begin
                        err_pulse <= 1'b1;
                        if (err_cnt != '1)
                            err_cnt <= err_cnt + 1'b1;
                        state  <= HUNT;
                        locked <= 1'b0;
                    end else if (tmr == TMR_LAST) begin
                        stall  <= 1'b1;
                        state  <= HUNT;
                        locked <= 1'b0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_pattern_checker.sv
// Purpose: self-checking bench for ring_pattern_checker against a behavioural model of the ring rules.
// Latency: n/a (bench); expects 2 clk ring_in-to-pulse, 4 clk when RING_CHK_SYNC_EN is defined.
// Backpressure: n/a.
module tb_ring_pattern_checker;

    localparam int W   = 16;
    localparam int LC  = 4;
    localparam int TO  = 50;
    localparam int TW  = 6;
    localparam int CW  = 16;
`ifdef RING_CHK_SYNC_EN
    localparam int SYNC_D = 3;
`else
    localparam int SYNC_D = 1;
`endif
    localparam int LAT = SYNC_D + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  ring_in = '0;
    logic          locked;
    logic          stall;
    logic          step_pulse;
    logic          err_pulse;
    logic [CW-1:0] step_cnt;
    logic [CW-1:0] err_cnt;

    always #5 clk = ~clk;

    ring_pattern_checker #(
        .WIDTH      (W),
        .LOCK_COUNT (LC),
        .TIMEOUT    (TO),
        .TMR_W      (TW),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ring_in    (ring_in),
        .locked     (locked),
        .stall      (stall),
        .step_pulse (step_pulse),
        .err_pulse  (err_pulse),
        .step_cnt   (step_cnt),
        .err_cnt    (err_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: mode 0 searching, 1 counting good steps, 2 locked.
    int           m_mode;
    int           m_run;
    int           m_edge;
    int           m_last_evt;
    logic [W-1:0] m_hist [3];
    logic [W-1:0] m_s;
    logic [W-1:0] m_prev;
    logic         e_locked, e_stall, e_step, e_err;
    int           e_step_cnt, e_err_cnt;

    logic [W-1:0] cur;
    int           obs_steps, obs_errs;

    function automatic int ones(input logic [W-1:0] x);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) if (x[i]) n++;
        return n;
    endfunction

    function automatic int pos(input logic [W-1:0] x);
        for (int i = 0; i < W; i++) if (x[i]) return i;
        return -1;
    endfunction

    // b is the ring position immediately after a (both single-bit, index +1 modulo W).
    function automatic logic is_next(input logic [W-1:0] a, input logic [W-1:0] b);
        return (ones(a) == 1) && (ones(b) == 1) && (pos(b) == (pos(a) + 1) % W);
    endfunction

    function automatic logic [W-1:0] nxt(input logic [W-1:0] x);
        logic [W-1:0] r;
        r = '0;
        r[(pos(x) + 1) % W] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_run = 0; m_edge = 0; m_last_evt = 0;
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
        m_s = '0; m_prev = '0;
        e_locked = 1'b0; e_stall = 1'b0; e_step = 1'b0; e_err = 1'b0;
        e_step_cnt = 0; e_err_cnt = 0;
    endtask

    task automatic model_edge(input logic [W-1:0] v);
        logic chg, gd;
        m_edge++;
        chg = (m_s != m_prev);
        gd  = chg && is_next(m_prev, m_s);
        e_step = 1'b0;
        e_err  = 1'b0;
        if (chg) e_stall = 1'b0;
        case (m_mode)
            0: if (ones(m_s) == 1) begin m_mode = 1; m_run = 0; end
            1: begin
                if (gd) begin
                    m_run++;
                    if (m_run == LC) begin m_mode = 2; m_last_evt = m_edge; end
                end else if (chg) begin
                    m_mode = 0;
                end
            end
            default: begin
                if (gd) begin
                    e_step = 1'b1;
                    e_step_cnt = (e_step_cnt + 1) % (1 << CW);
                    m_last_evt = m_edge;
                end else if (chg) begin
                    e_err = 1'b1;
                    if (e_err_cnt < (1 << CW) - 1) e_err_cnt++;
                    m_mode = 0;
                end else if (m_edge - m_last_evt == TO) begin
                    e_stall = 1'b1;
                    m_mode = 0;
                end
            end
        endcase
        e_locked = (m_mode == 2);
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = v;
        m_prev = m_s;
        m_s = m_hist[SYNC_D-1];
    endtask

    // Drive v, advance one clock, sample 1 time unit after the edge.
    task automatic tick(input logic [W-1:0] v);
        ring_in = v;
        @(posedge clk);
        model_edge(v);
        #1;
        if (step_pulse) obs_steps++;
        if (err_pulse) obs_errs++;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({locked, stall, step_pulse, err_pulse} !== 4'b0 || step_cnt !== '0 || err_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got l/s/p/e=%b%b%b%b cnt=%0d/%0d, want all 0",
                     locked, stall, step_pulse, err_pulse, step_cnt, err_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequence();
        obs_steps = 0;
        cur = 16'h0001;
        for (int s = 0; s < 15; s++) begin
            for (int k = 0; k < 10; k++) begin
                tick(cur);
                n_checks++;
                if ({locked, stall, step_pulse, err_pulse} !== {e_locked, e_stall, e_step, e_err} ||
                    step_cnt !== CW'(e_step_cnt) || err_cnt !== CW'(e_err_cnt)) begin
                    n_fail++;
                    $display("FAIL seq_cycle t=%0t: got l/s/p/e=%b%b%b%b cnt=%0d/%0d want %b%b%b%b %0d/%0d",
                             $time, locked, stall, step_pulse, err_pulse, step_cnt, err_cnt,
                             e_locked, e_stall, e_step, e_err, e_step_cnt, e_err_cnt);
                end
            end
            if (s == 3) begin
                n_checks++;
                if (locked !== 1'b0) begin
                    n_fail++;
                    $display("FAIL seq_not_yet_locked: locked=%b after 3 good steps, want 0", locked);
                end
            end
            if (s == 4) begin
                n_checks++;
                if (locked !== 1'b1 || obs_steps != 0) begin
                    n_fail++;
                    $display("FAIL seq_lock_at_4: locked=%b steps=%0d, want 1 and 0", locked, obs_steps);
                end
            end
            if (s < 14) cur = nxt(cur);
        end
        n_checks++;
        if (step_cnt !== 16'd10 || err_cnt !== 16'd0 || obs_steps != 10) begin
            n_fail++;
            $display("FAIL seq_10_steps: step_cnt=%0d err_cnt=%0d pulses=%0d, want 10 0 10",
                     step_cnt, err_cnt, obs_steps);
        end
    endtask

    task automatic test_wrap();
        obs_steps = 0; obs_errs = 0;
        repeat (10) tick(16'h8000);
        repeat (10) tick(16'h0001);
        n_checks++;
        if (obs_steps != 2 || obs_errs != 0 || locked !== 1'b1 || step_cnt !== 16'd12) begin
            n_fail++;
            $display("FAIL wrap: steps=%0d errs=%0d locked=%b step_cnt=%0d, want 2 0 1 12",
                     obs_steps, obs_errs, locked, step_cnt);
        end
        cur = 16'h0001;
        for (int s = 0; s < 4; s++) begin
            cur = nxt(cur);
            repeat (10) tick(cur);
        end
    endtask

    task automatic test_bad();
        obs_steps = 0; obs_errs = 0;
        repeat (10) tick(16'h0040);
        n_checks++;
        if (obs_errs != 1 || err_cnt !== 16'd1 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_skip: errs=%0d err_cnt=%0d locked=%b, want 1 1 0", obs_errs, err_cnt, locked);
        end
        repeat (10) tick(16'h0041);
        n_checks++;
        if (locked !== 1'b0 || obs_errs != 1) begin
            n_fail++;
            $display("FAIL bad_multihot: locked=%b errs=%0d, want 0 1", locked, obs_errs);
        end
        cur = 16'h0080;
        repeat (10) tick(cur);
        for (int s = 0; s < 4; s++) begin
            cur = nxt(cur);
            repeat (10) tick(cur);
            if (s == 2) begin
                n_checks++;
                if (locked !== 1'b0) begin
                    n_fail++;
                    $display("FAIL relock_early: locked=%b after 3 good steps, want 0", locked);
                end
            end
        end
        n_checks++;
        if (locked !== 1'b1 || step_cnt !== 16'd16 || obs_steps != 0) begin
            n_fail++;
            $display("FAIL relock: locked=%b step_cnt=%0d steps=%0d, want 1 16 0", locked, step_cnt, obs_steps);
        end
    endtask

    task automatic test_stall();
        int t_step, t_stall;
        logic l_at_stall;
        t_step = -1; t_stall = -1; l_at_stall = 1'b1;
        cur = nxt(cur);
        for (int t = 1; t <= 70; t++) begin
            tick(cur);
            if (step_pulse) t_step = t;
            if (stall && t_stall < 0) begin t_stall = t; l_at_stall = locked; end
            n_checks++;
            if ({locked, stall, step_pulse, err_pulse} !== {e_locked, e_stall, e_step, e_err} ||
                step_cnt !== CW'(e_step_cnt) || err_cnt !== CW'(e_err_cnt)) begin
                n_fail++;
                $display("FAIL stall_cycle t=%0t: got l/s/p/e=%b%b%b%b cnt=%0d/%0d want %b%b%b%b %0d/%0d",
                         $time, locked, stall, step_pulse, err_pulse, step_cnt, err_cnt,
                         e_locked, e_stall, e_step, e_err, e_step_cnt, e_err_cnt);
            end
        end
        n_checks++;
        if (t_step < 0 || t_stall - t_step != TO || l_at_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_timing: gap=%0d locked=%b (step@%0d stall@%0d), want gap %0d locked 0",
                     t_stall - t_step, l_at_stall, t_step, t_stall, TO);
        end
        cur = nxt(cur);
        repeat (10) tick(cur);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_clear: stall=%b after bus change, want 0", stall);
        end
        for (int s = 0; s < 3; s++) begin
            cur = nxt(cur);
            repeat (10) tick(cur);
        end
        n_checks++;
        if (locked !== 1'b1 || step_cnt !== 16'd17) begin
            n_fail++;
            $display("FAIL stall_relock: locked=%b step_cnt=%0d, want 1 17", locked, step_cnt);
        end
    endtask

    task automatic test_race();
        logic stall_seen;
        stall_seen = 1'b0;
        obs_steps = 0;
        for (int s = 0; s < 3; s++) begin
            cur = nxt(cur);
            repeat ((s < 2) ? TO : 10) begin
                tick(cur);
                if (stall) stall_seen = 1'b1;
            end
        end
        n_checks++;
        if (stall_seen !== 1'b0 || obs_steps != 3 || locked !== 1'b1 || step_cnt !== 16'd20) begin
            n_fail++;
            $display("FAIL race: stall_seen=%b steps=%0d locked=%b step_cnt=%0d, want 0 3 1 20",
                     stall_seen, obs_steps, locked, step_cnt);
        end
    endtask

    task automatic test_latency();
        int lat;
        lat = -1;
        cur = nxt(cur);
        for (int k = 1; k <= 10; k++) begin
            tick(cur);
            if (step_pulse && lat < 0) lat = k;
        end
        n_checks++;
        if (lat != LAT) begin
            n_fail++;
            $display("FAIL latency: step_pulse after %0d clk, want %0d", lat, LAT);
        end
    endtask

    task automatic test_random();
        int r, hold;
        logic [W-1:0] tmp;
        for (int a = 0; a < 150; a++) begin
            r = int'($urandom_range(0, 99));
            hold = int'($urandom_range(1, 12));
            if (r < 65) begin
                cur = nxt(cur);
            end else if (r < 75) begin
                tmp = '0;
                tmp[$urandom_range(0, W-1)] = 1'b1;
                cur = tmp;
            end else if (r < 85) begin
                cur = W'($urandom);
            end else begin
                hold = int'($urandom_range(TO - 2, TO + 2));
            end
            for (int k = 0; k < hold; k++) begin
                tick(cur);
                n_checks++;
                if ({locked, stall, step_pulse, err_pulse} !== {e_locked, e_stall, e_step, e_err} ||
                    step_cnt !== CW'(e_step_cnt) || err_cnt !== CW'(e_err_cnt)) begin
                    n_fail++;
                    $display("FAIL random t=%0t in=%h: got l/s/p/e=%b%b%b%b cnt=%0d/%0d want %b%b%b%b %0d/%0d",
                             $time, cur, locked, stall, step_pulse, err_pulse, step_cnt, err_cnt,
                             e_locked, e_stall, e_step, e_err, e_step_cnt, e_err_cnt);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                cur = 16'h0001;
                repeat (5) tick(cur);
                for (int s = 0; s < 4 + 7; s++) begin
                    cur = nxt(cur);
                    repeat (5) tick(cur);
                end
                n_checks++;
                if (locked !== 1'b1 || step_cnt !== 16'd7) begin
                    n_fail++;
                    $display("FAIL areset_setup: locked=%b step_cnt=%0d, want 1 7", locked, step_cnt);
                end
            end
            #2;
            rst_n = 1'b0;
            #1;
            n_checks++;
            if ({locked, stall, step_pulse, err_pulse} !== 4'b0 || step_cnt !== '0 || err_cnt !== '0) begin
                n_fail++;
                $display("FAIL areset_pass%0d: got l/s/p/e=%b%b%b%b cnt=%0d/%0d, want all 0 before edge",
                         pass, locked, stall, step_pulse, err_pulse, step_cnt, err_cnt);
            end
            model_reset();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequence();
        test_wrap();
        test_bad();
        test_stall();
        test_race();
        test_latency();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
